seg_p2s: RTL and testbench

SEG_P2S -- requirements
Module: seg_p2s

---
 rtl/seg_p2s_pkg.sv | 19 +
 rtl/seg_p2s_tick.sv | 54 +++++
 rtl/seg_p2s.sv | 110 +++++++++++
 tb/tb_seg_p2s.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_p2s_pkg.sv
// Shared types and defaults for the parallel-to-serial segment driver.
package seg_p2s_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StLatch,
        StDone
    } state_e;

    localparam int unsigned DefaultWidth = 64;
    localparam int unsigned DefaultDiv   = 2;

    // A counter for n states needs at least one bit even when n is 1.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_p2s_tick.sv
// Serial-clock divider: produces the s_clk phase plus half-period and
// end-of-bit-period pulses while enabled; idles at phase 0 otherwise.
module seg_p2s_tick
    import seg_p2s_pkg::*;
#(
    parameter int unsigned DIV = DefaultDiv
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic toggle_i,
    output logic phase_o,
    output logic half_end_o,
    output logic period_end_o
);

    localparam int unsigned CntW = cnt_bits(DIV);
    localparam logic [CntW-1:0] DivLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        half_end_o   = en_i && (cnt_q == DivLast);
        period_end_o = half_end_o && phase_q && toggle_i;
        if (!en_i) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (half_end_o) begin
            cnt_d = '0;
            // With toggle_i low the divider still counts but s_clk stays low.
            if (toggle_i) begin
                phase_d = ~phase_q;
            end
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/seg_p2s.sv
// Shifts a WIDTH-bit frame out MSB first on s_clk/s_data, then strobes
// s_latch for DIV cycles and pulses done.
module seg_p2s
    import seg_p2s_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned DIV   = DefaultDiv
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] par_in,
    output logic             s_clk,
    output logic             s_data,
    output logic             s_latch,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BitW-1:0]  bit_q, bit_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic tick_en, tick_toggle, half_end, period_end, phase;

    assign tick_en     = (state_q == StShift) || (state_q == StLatch);
    assign tick_toggle = (state_q == StShift);

    seg_p2s_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .en_i         (tick_en),
        .toggle_i     (tick_toggle),
        .phase_o      (phase),
        .half_end_o   (half_end),
        .period_end_o (period_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d = par_in;
                    bit_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (period_end) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    bit_d   = bit_q + BitW'(1);
                    if (bit_q == LastBit) begin
                        state_d = StLatch;
                    end
                end
            end
            StLatch: begin
                if (half_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Status outputs are registered copies of the next state.
        latch_d = (state_d == StLatch);
        busy_d  = (state_d == StShift) || (state_d == StLatch);
        done_d  = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            bit_q   <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_clk   = phase;
    assign s_data  = shift_q[WIDTH-1];
    assign s_latch = latch_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seg_p2s.sv
// Scoreboard bench for seg_p2s: a 64-bit/DIV=2 instance fed random frames
// and an 8-bit/DIV=1 instance checked bit by bit.
module tb_seg_p2s;

    localparam int unsigned W    = 64;
    localparam int unsigned D    = 2;
    localparam int unsigned LAT  = W * 2 * D + D;
    localparam int unsigned WB   = 8;
    localparam int unsigned DB   = 1;
    localparam int unsigned LATB = WB * 2 * DB + DB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0;
    logic          start_b = 1'b0;
    logic [W-1:0]  par_a = '0;
    logic [WB-1:0] par_b = '0;
    logic s_clk_a, s_data_a, s_latch_a, busy_a, done_a;
    logic s_clk_b, s_data_b, s_latch_b, busy_b, done_b;

    seg_p2s #(.WIDTH(W), .DIV(D)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .par_in(par_a),
        .s_clk(s_clk_a), .s_data(s_data_a), .s_latch(s_latch_a),
        .busy(busy_a), .done(done_a)
    );

    seg_p2s #(.WIDTH(WB), .DIV(DB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .par_in(par_b),
        .s_clk(s_clk_b), .s_data(s_data_b), .s_latch(s_latch_b),
        .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one frame in flight; a start is taken only once the
    // previous frame's done cycle has passed.
    typedef struct {
        logic [W-1:0] frame;
        int unsigned  done_cyc;
    } exp_t;
    exp_t        exp_q[$];
    int unsigned next_free = 0;

    task automatic drive_a(input logic s, input logic [W-1:0] p);
        @(negedge clk);
        start_a = s;
        par_a   = p;
        if (s && !rst && (cyc + 1 >= next_free)) begin
            exp_q.push_back('{frame: p, done_cyc: cyc + 1 + LAT});
            next_free = cyc + 1 + LAT + 2;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) drive_a(1'b0, '0);
        check("drain_a", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Monitor A: downstream shift register model plus pulse checks.
    logic [W-1:0] sh_a;
    int unsigned  rises_a = 0;
    int unsigned  latch_len = 0;
    logic pclk_a = 1'b0, plat_a = 1'b0, pdone_a = 1'b0, pdata_a = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sh_a = '0; rises_a = 0; latch_len = 0;
            pclk_a = 1'b0; plat_a = 1'b0; pdone_a = 1'b0; pdata_a = 1'b0;
        end else begin
            if (s_clk_a && !pclk_a) begin
                check("sdata_stable_at_rise", 64'(s_data_a), 64'(pdata_a));
                check("busy_at_rise", 64'(busy_a), 64'd1);
                sh_a = {sh_a[W-2:0], s_data_a};
                rises_a++;
            end
            if (s_latch_a) latch_len++;
            if (s_latch_a && !plat_a) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_latch", 64'd1, 64'd0);
                end else begin
                    check("frame", sh_a, exp_q[0].frame);
                    check("rises_per_frame", 64'(rises_a), 64'(W));
                end
                rises_a = 0;
            end
            if (!s_latch_a && plat_a) begin
                check("latch_width", 64'(latch_len), 64'(D));
                latch_len = 0;
            end
            if (done_a) begin
                check("busy_in_done", 64'(busy_a), 64'd0);
                check("done_single", 64'(pdone_a), 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    check("done_latency", 64'(cyc), 64'(exp_q[0].done_cyc));
                    void'(exp_q.pop_front());
                end
            end
            pclk_a = s_clk_a; plat_a = s_latch_a; pdone_a = done_a; pdata_a = s_data_a;
        end
    end

    // Monitor B: expected serial bits and done cycles.
    logic        bq[$];
    int unsigned bdone[$];
    logic pclk_b = 1'b0, pshift_b = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            pclk_b = 1'b0; pshift_b = 1'b0;
        end else begin
            if (pshift_b && busy_b && !s_latch_b)
                check("b_toggle", 64'(s_clk_b), 64'(!pclk_b));
            if (s_clk_b && !pclk_b) begin
                if (bq.size() == 0) check("b_unexpected_rise", 64'd1, 64'd0);
                else check("b_bit", 64'(s_data_b), 64'(bq.pop_front()));
            end
            if (done_b) begin
                if (bdone.size() == 0) check("b_unexpected_done", 64'd1, 64'd0);
                else check("b_latency", 64'(cyc), 64'(bdone.pop_front()));
            end
            pclk_b = s_clk_b;
            pshift_b = busy_b && !s_latch_b;
        end
    end

    initial begin
        logic [WB-1:0] bvals[2];

        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({s_clk_a, s_data_a, s_latch_a, busy_a, done_a,
                   s_clk_b, s_data_b, s_latch_b, busy_b, done_b}), 64'd0);
        rst = 1'b0;
        next_free = cyc + 1;

        drive_a(1'b1, 64'hDEADBEEF_01234567);
        drive_a(1'b0, '0);
        wait_idle();

        drive_a(1'b1, 64'h8000_0000_0000_0001);
        drive_a(1'b0, '0);
        wait_idle();

        // start held high with new data every cycle
        for (int i = 0; i < 300; i++) drive_a(1'b1, {$urandom, $urandom});
        drive_a(1'b0, '0);
        wait_idle();

        for (int f = 0; f < 4; f++) begin
            drive_a(1'b1, {$urandom, $urandom});
            for (int i = 0; i < int'($urandom_range(0, 300)); i++)
                drive_a($urandom_range(0, 7) == 0, {$urandom, $urandom});
        end
        drive_a(1'b0, '0);
        wait_idle();

        // asynchronous reset part-way through a frame
        drive_a(1'b1, {$urandom, $urandom});
        for (int i = 0; i < 200 && rises_a < 20; i++) drive_a(1'b0, '0);
        check("rise20_reached", 64'(rises_a), 64'd20);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs",
                 64'({s_clk_a, s_data_a, s_latch_a, busy_a, done_a}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_free = cyc + 1;
        for (int i = 0; i < 10; i++) drive_a(1'b0, '0);
        drive_a(1'b1, {W{1'b1}});
        drive_a(1'b0, '0);
        wait_idle();

        bvals[0] = 8'hA5;
        bvals[1] = 8'($urandom);
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            start_b = 1'b1;
            par_b   = bvals[f];
            for (int i = WB - 1; i >= 0; i--) bq.push_back(bvals[f][i]);
            bdone.push_back(cyc + 1 + LATB);
            @(negedge clk);
            start_b = 1'b0;
            for (int i = 0; i < 100 && bdone.size() != 0; i++) @(negedge clk);
            check("b_drain", 64'(bdone.size() + bq.size()), 64'd0);
            bdone.delete();
            bq.delete();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
